// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single-port word memory, with one-deep read tracking.
// Define ARB_FIXED_PRIO_EN to give requester 0 absolute priority instead of round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, PEND0, PEND1} state_t;

    state_t state, state_next;
    logic   rd_gnt0, rd_gnt1;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0_o = !rst_i && req0_i;
        gnt1_o = !rst_i && req1_i && !req0_i;
    end
`else
    // last_gnt = 1 means requester 0 wins the next conflict.
    logic last_gnt;

    always_comb begin
        gnt0_o = !rst_i && req0_i && (!req1_i || last_gnt);
        gnt1_o = !rst_i && req1_i && (!req0_i || !last_gnt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)       last_gnt <= 1'b1;
        else if (gnt0_o) last_gnt <= 1'b0;
        else if (gnt1_o) last_gnt <= 1'b1;
    end
`endif

    always_comb begin
        mem_addr_o  = '0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_wdata_o = '0;
        if (gnt0_o) begin
            mem_addr_o  = addr0_i;
            mem_rd_en_o = !we0_i;
            mem_wr_en_o = we0_i;
            mem_wdata_o = wdata0_i;
        end else if (gnt1_o) begin
            mem_addr_o  = addr1_i;
            mem_rd_en_o = !we1_i;
            mem_wr_en_o = we1_i;
            mem_wdata_o = wdata1_i;
        end
    end

    assign rd_gnt0 = gnt0_o && !we0_i;
    assign rd_gnt1 = gnt1_o && !we1_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (rd_gnt0)      state_next = PEND0;
        else if (rd_gnt1) state_next = PEND1;
    end

    // Gating with rst_i drops a read whose data would land during reset.
    always_comb begin
        rvalid0_o = !rst_i && (state == PEND0);
        rvalid1_o = !rst_i && (state == PEND1);
        rdata0_o  = rvalid0_o ? mem_data_i : '0;
        rdata1_o  = rvalid1_o ? mem_data_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a random run against a request-level model.
module tb_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [9:0]  mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_wdata, mem_data;

    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en),
        .mem_wdata_o(mem_wdata), .mem_data_i(mem_data)
    );

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return {12'h5A5, a, ~a};
    endfunction

    // Word memory with one-cycle read latency; unwritten words read as init_val.
    logic [31:0] mem [0:1023];
    bit          mem_set [0:1023];
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
            mem_set[pl_addr] <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            mem_set[mem_addr] <= 1'b1;
        end
        if (mem_rd_en) mem_data <= mem_set[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        req0 = 1; we0 = 0; addr0 = 10'h010;
        req1 = 1; we1 = 0; addr1 = 10'h020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({gnt1, gnt0} !== 2'b00) begin
                n_fail++; $display("FAIL reset_gnt: got %b want 00", {gnt1, gnt0});
            end
            n_checks++;
            if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== '0) begin
                n_fail++; $display("FAIL reset_mem: got rd=%b wr=%b addr=%h wd=%h want all 0",
                                   mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
            end
            n_checks++;
            if ({rvalid1, rvalid0, rdata1, rdata0} !== '0) begin
                n_fail++; $display("FAIL reset_rvalid: got rv=%b%b rd0=%h rd1=%h want all 0",
                                   rvalid1, rvalid0, rdata0, rdata1);
            end
            tick();
        end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_gnt: got %b want 01", {gnt1, gnt0});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_single_read();
        pl_addr = 10'h004; pl_data = 32'hDEADBEEF; pl_en = 1;
        tick();
        pl_en = 0;
        req0 = 1; we0 = 0; addr0 = 10'h004;
        @(negedge clk);
        n_checks++;
        if ({gnt1, gnt0, mem_rd_en, mem_wr_en, mem_addr} !== {4'b0110, 10'h004}) begin
            n_fail++; $display("FAIL single_read_grant: got gnt=%b%b rd=%b wr=%b addr=%h want 01 1 0 004",
                               gnt1, gnt0, mem_rd_en, mem_wr_en, mem_addr);
        end
        tick();
        req0 = 0;
        @(negedge clk);
        n_checks++;
        if ({rvalid1, rvalid0, rdata0, rdata1} !== {2'b01, 32'hDEADBEEF, 32'h0}) begin
            n_fail++; $display("FAIL single_read_data: got rv=%b%b rd0=%h rd1=%h want 01 deadbeef 0",
                               rvalid1, rvalid0, rdata0, rdata1);
        end
        tick();
    endtask

    task automatic test_contention();
        int w, prev;
        logic [31:0] exp_d;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 10'h010;
        req1 = 1; we1 = 0; addr1 = 10'h020;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            w = FIXED ? 0 : (i % 2);
            @(negedge clk);
            n_checks++;
            if ({gnt1, gnt0} !== (w == 0 ? 2'b01 : 2'b10) ||
                mem_addr !== (w == 0 ? 10'h010 : 10'h020)) begin
                n_fail++; $display("FAIL contention_gnt[%0d]: got gnt=%b%b addr=%h want winner %0d",
                                   i, gnt1, gnt0, mem_addr, w);
            end
            if (prev >= 0) begin
                exp_d = init_val(prev == 0 ? 10'h010 : 10'h020);
                n_checks++;
                if ({rvalid1, rvalid0} !== (prev == 0 ? 2'b01 : 2'b10) ||
                    (prev == 0 ? rdata0 : rdata1) !== exp_d) begin
                    n_fail++; $display("FAIL contention_rdata[%0d]: got rv=%b%b rd0=%h rd1=%h want req%0d %h",
                                       i, rvalid1, rvalid0, rdata0, rdata1, prev, exp_d);
                end
            end
            prev = w;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        exp_d = init_val(prev == 0 ? 10'h010 : 10'h020);
        n_checks++;
        if ({rvalid1, rvalid0} !== (prev == 0 ? 2'b01 : 2'b10) ||
            (prev == 0 ? rdata0 : rdata1) !== exp_d) begin
            n_fail++; $display("FAIL contention_last_rdata: got rv=%b%b rd0=%h rd1=%h want req%0d %h",
                               rvalid1, rvalid0, rdata0, rdata1, prev, exp_d);
        end
        tick();
    endtask

    task automatic test_write_read();
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if ({gnt1, gnt0, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {4'b1010, 10'h3FF, 32'h12345678}) begin
            n_fail++; $display("FAIL write_grant: got gnt=%b%b wr=%b rd=%b addr=%h wd=%h want 10 1 0 3ff 12345678",
                               gnt1, gnt0, mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
        end
        tick();
        we1 = 0;
        @(negedge clk);
        n_checks++;
        if ({gnt1, mem_wr_en, mem_rd_en, mem_addr, rvalid1, rvalid0} !== {3'b101, 10'h3FF, 2'b00}) begin
            n_fail++; $display("FAIL read_after_write_grant: got gnt1=%b wr=%b rd=%b addr=%h rv=%b%b want 1 0 1 3ff 00",
                               gnt1, mem_wr_en, mem_rd_en, mem_addr, rvalid1, rvalid0);
        end
        tick();
        req1 = 0;
        @(negedge clk);
        n_checks++;
        if ({rvalid1, rvalid0, rdata1} !== {2'b10, 32'h12345678}) begin
            n_fail++; $display("FAIL read_after_write_data: got rv=%b%b rd1=%h want 10 12345678",
                               rvalid1, rvalid0, rdata1);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1; we0 = 0; addr0 = 10'h004;
        @(negedge clk);
        n_checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_fail++; $display("FAIL midreset_grant: got %b want 01", {gnt1, gnt0});
        end
        tick();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        n_checks++;
        if ({rvalid1, rvalid0, rdata0} !== '0) begin
            n_fail++; $display("FAIL midreset_n1: got rv=%b%b rd0=%h want 00 0", rvalid1, rvalid0, rdata0);
        end
        tick();
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({rvalid1, rvalid0, rdata0} !== '0) begin
            n_fail++; $display("FAIL midreset_n2: got rv=%b%b rd0=%h want 00 0", rvalid1, rvalid0, rdata0);
        end
        tick();
    endtask

    // Model: whoever did not win the last grant wins the next conflict;
    // a read grant returns that address's current contents on the next cycle.
    task automatic test_random();
        bit          act [2];
        bit          rwe [2];
        logic [9:0]  raddr [2];
        logic [31:0] rwd [2];
        logic [31:0] ref_val [0:1023];
        bit          ref_set [0:1023];
        int          favor, w, pend;
        logic [31:0] pdata, exp_wd;
        logic [9:0]  exp_a;
        logic        exp_rd, exp_wr;
        logic [1:0]  exp_g, exp_rv;

        for (int i = 0; i < 1024; i++) ref_set[i] = 0;
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; rwe[k] = 0; raddr[k] = '0; rwd[k] = '0;
        end
        do_reset();
        favor = 0; pend = -1; pdata = '0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!act[k] && $urandom_range(9) < 6) begin
                    act[k]   = 1;
                    rwe[k]   = 1'($urandom_range(1));
                    raddr[k] = 10'h100 + 10'($urandom_range(15));
                    rwd[k]   = $urandom;
                end else if (act[k] && $urandom_range(19) == 0) begin
                    act[k] = 0;
                end
            end
            req0 = act[0]; we0 = rwe[0]; addr0 = raddr[0]; wdata0 = rwd[0];
            req1 = act[1]; we1 = rwe[1]; addr1 = raddr[1]; wdata1 = rwd[1];

            if (act[0] && act[1]) w = FIXED ? 0 : favor;
            else if (act[0])      w = 0;
            else if (act[1])      w = 1;
            else                  w = -1;

            exp_g = 2'b00; exp_rd = 0; exp_wr = 0; exp_a = '0; exp_wd = '0;
            if (w >= 0) begin
                exp_g  = (w == 0) ? 2'b01 : 2'b10;
                exp_rd = !rwe[w];
                exp_wr = rwe[w];
                exp_a  = raddr[w];
                exp_wd = rwd[w];
            end
            exp_rv = (pend == 0) ? 2'b01 : (pend == 1) ? 2'b10 : 2'b00;

            @(negedge clk);
            n_checks++;
            if ({gnt1, gnt0} !== exp_g) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, {gnt1, gnt0}, exp_g);
            end
            n_checks++;
            if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== {exp_rd, exp_wr, exp_a, exp_wd}) begin
                n_fail++; $display("FAIL rand_mem[%0d]: got rd=%b wr=%b addr=%h wd=%h want %b %b %h %h",
                                   c, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, exp_rd, exp_wr, exp_a, exp_wd);
            end
            n_checks++;
            if ({rvalid1, rvalid0} !== exp_rv ||
                rdata0 !== ((pend == 0) ? pdata : 32'h0) ||
                rdata1 !== ((pend == 1) ? pdata : 32'h0)) begin
                n_fail++; $display("FAIL rand_rvalid[%0d]: got rv=%b rd0=%h rd1=%h want rv=%b data=%h",
                                   c, {rvalid1, rvalid0}, rdata0, rdata1, exp_rv, pdata);
            end

            pend = -1;
            if (w >= 0) begin
                favor  = 1 - w;
                act[w] = 0;
                if (rwe[w]) begin
                    ref_val[raddr[w]] = rwd[w];
                    ref_set[raddr[w]] = 1;
                end else begin
                    pend  = w;
                    pdata = ref_set[raddr[w]] ? ref_val[raddr[w]] : init_val(raddr[w]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        pl_en = 0; pl_addr = '0; pl_data = '0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
